layer_sequencer: RTL and testbench
==================================

# layer_sequencer

Top-level per-layer sequencer for the 14×14 weight-stationary sparse accelerator. It walks a small layer-descriptor table, and for each layer it:
- launches the weight/metadata DMA,
- clears the PE accumulators,
- starts the BSR scheduler and waits for it to finish,
- triggers the output drain.

It sits between the CSR block and the DMA, BSR scheduler and output-drain engines. It owns all their start/abort pulses and reports aggregate busy/done/error.

## Interface
- `M_W`, 10, width of M tile count (matches scheduler)
- `K_W`, 12, width of K tile count (matches scheduler)
- `ADDR_W`, 32, DMA/drain byte-address width
- `DESC_AW`, 3, descriptor-table address width (max 8 layers)
- `TMO_W`, 20, watchdog counter width; timeout fires at 2^TMO_W−1 cycles

Ports:
- `clk` in 1: single clock. `rst_n` in 1: reset, asynchronous, active-low.
- `start` in 1: pulse; begins a run. Ignored while busy.
- `abort` in 1: level/pulse; stops the run.
- `num_layers` in DESC_AW+1: layer count, sampled on accepted start.
- `busy` out 1 · `done` out 1 (pulse) · `error` out 1 (sticky) · `err_code` out 2 · `cur_layer` out DESC_AW
- `desc_rd_addr` out DESC_AW: descriptor table address; data is valid the cycle after the address is presented.
- `desc_mt` in M_W · `desc_kt` in K_W · `desc_wgt_base` in ADDR_W · `desc_out_base` in ADDR_W
- `dma_start` out 1 (pulse) · `dma_base` out ADDR_W · `dma_done` in 1 (pulse) · `dma_err` in 1 (pulse)
- `pe_clr` out 1 (pulse)
- `sched_start` out 1 (pulse) · `sched_abort` out 1 (pulse) · `sched_mt` out M_W · `sched_kt` out K_W · `sched_done` in 1 (pulse)
- `drain_start` out 1 (pulse) · `drain_base` out ADDR_W · `drain_done` in 1 (pulse)

## Operation

States are one-hot, in this order:
- **S_IDLE**
  - Accepted `start` with `num_layers`≠0 → S_DESC_ADDR. Latch the count, set `cur_layer`=0, set `busy`=1, clear `error`/`err_code`.
  - `start` with `num_layers`=0 → pulse `done` next cycle; `busy` stays 0.
- **S_DESC_ADDR**: drive `desc_rd_addr`=`cur_layer`. Go to S_DESC_CAP.
- **S_DESC_CAP**: register MT, KT, wgt_base and out_base into internal regs. Those regs drive `sched_mt`/`sched_kt`/`dma_base`/`drain_base`, which stay stable until the next capture.
  - MT=0 → skip straight to S_NEXT (no sub-block is started).
  - Otherwise → S_LOAD.
- **S_LOAD**: on entry pulse `dma_start`, then wait for `dma_done` → S_CLEAR.
- **S_CLEAR**: 1 cycle with `pe_clr`=1 → S_COMPUTE.
- **S_COMPUTE**: on entry pulse `sched_start`, then wait for `sched_done` → S_DRAIN.
- **S_DRAIN**: on entry pulse `drain_start`, then wait for `drain_done` → S_NEXT.
- **S_NEXT**
  - If `cur_layer`+1 < count: increment `cur_layer` → S_DESC_ADDR.
  - Otherwise: pulse `done`, drop `busy` → S_IDLE.
- **S_ERR**: 1 cycle. Pulse `sched_abort`, drop `busy` → S_IDLE. `error` stays 1 until the next accepted start.

Error codes:
- 1 = `dma_err` seen in S_LOAD.
- 2 = `abort`.
- 3 = watchdog timeout in any wait state.
- Priority when several occur together: abort > dma_err > timeout.

Watchdog:
- Zeroed on entry to S_LOAD, S_COMPUTE and S_DRAIN; increments each cycle while waiting.
- A completion pulse arriving in the same cycle as saturation wins; no error is raised.

Abort:
- `abort` in any non-IDLE state → S_ERR (code 2). `done` is not pulsed.
- `abort` in S_IDLE has no effect.

## Timing
- Reset values: every output is 0; state is S_IDLE.
- All outputs are registered.
- Each pulse output (`done`, `dma_start`, `pe_clr`, `sched_start`, `sched_abort`, `drain_start`) is high for exactly 1 cycle per event.
- `start` sampled at edge T:
  - `busy`=1 and `desc_rd_addr` valid at T+1;
  - descriptor captured at T+2;
  - `dma_start` high at T+3.
- Completion pulse at edge T → the next phase's start pulse is high at T+1. The only exception is `pe_clr`: `dma_done` at T gives `pe_clr` at T+1 and `sched_start` at T+2.
- Last layer: `drain_done` at T → `done`=1 and `busy`=0 at T+2.
- Stray completion pulses arriving outside their own wait state are ignored.
- `start` together with `abort` in S_IDLE: start is accepted, and the abort is applied on the following cycle.

## Structure
- Shared package `accel_ctrl_pkg`:
  - state enum `layer_state_e`;
  - `err_code_e` {ERR_NONE, ERR_DMA, ERR_ABORT, ERR_TMO};
  - descriptor struct `layer_desc_t` (mt, kt, wgt_base, out_base).
- One natural sub-module: `phase_watchdog` (clear, enable, TMO_W counter, `expired` output), instantiated once.
- The rest is a single FSM plus datapath registers.

## Test plan
- **3-layer run:**
  - Stimulus: `num_layers`=3; descriptors MT=2/4/1; each responder returns done 5 cycles after its start.
  - Required: 3 each of `dma_start`, `pe_clr`, `sched_start`, `drain_start`; `sched_mt` sequence 2,4,1; one `done`; `error`=0.
- **Zero cases:**
  - `num_layers`=0 → `done` at T+1 and `busy` never 1.
  - A layer with MT=0 → no `dma_start` for that layer and `cur_layer` advances.
- **DMA error:** `dma_err` on layer 1 → `error`=1, `err_code`=1, `sched_abort` pulse, `busy`=0 two cycles later, no `done`.
- **Abort mid-compute:** `abort` 3 cycles after `sched_start` → S_ERR, `err_code`=2, single `sched_abort`; the next `start` clears `error` and the run completes normally.
- **Watchdog:** with TMO_W=4, withhold `drain_done` → `err_code`=3 after 15 wait cycles; delivering `drain_done` on exactly cycle 15 → no error.
- **Reset mid-run:** assert `rst_n`=0 in S_COMPUTE → all outputs 0 immediately; state is S_IDLE after release.

Source files
------------

// File: rtl/accel_ctrl_pkg.sv
// Shared types for the accelerator control path: sequencer states,
// error codes and the per-layer descriptor bundle.
package accel_ctrl_pkg;

    localparam int unsigned ACC_M_W    = 10;
    localparam int unsigned ACC_K_W    = 12;
    localparam int unsigned ACC_ADDR_W = 32;

    typedef enum logic [8:0] {
        S_IDLE      = 9'b0_0000_0001,
        S_DESC_ADDR = 9'b0_0000_0010,
        S_DESC_CAP  = 9'b0_0000_0100,
        S_LOAD      = 9'b0_0000_1000,
        S_CLEAR     = 9'b0_0001_0000,
        S_COMPUTE   = 9'b0_0010_0000,
        S_DRAIN     = 9'b0_0100_0000,
        S_NEXT      = 9'b0_1000_0000,
        S_ERR       = 9'b1_0000_0000
    } layer_state_e;

    typedef enum logic [1:0] {
        ERR_NONE  = 2'd0,
        ERR_DMA   = 2'd1,
        ERR_ABORT = 2'd2,
        ERR_TMO   = 2'd3
    } err_code_e;

    typedef struct packed {
        logic [ACC_M_W-1:0]    mt;
        logic [ACC_K_W-1:0]    kt;
        logic [ACC_ADDR_W-1:0] wgt_base;
        logic [ACC_ADDR_W-1:0] out_base;
    } layer_desc_t;

endpackage

// File: rtl/phase_watchdog.sv
// Saturating wait-phase counter; expired_o flags the wait cycle in
// which the count reaches its all-ones limit.
module phase_watchdog #(
    parameter int unsigned TMO_W = 20
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam logic [TMO_W-1:0] MAX  = '1;
    localparam logic [TMO_W-1:0] LAST = {{(TMO_W-1){1'b1}}, 1'b0};
    localparam logic [TMO_W-1:0] ONE  = {{(TMO_W-1){1'b0}}, 1'b1};

    logic [TMO_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (en_i && (cnt_q != MAX)) begin
            cnt_q <= cnt_q + ONE;
        end
    end

    assign expired_o = en_i && (cnt_q >= LAST);

endmodule

// File: rtl/layer_sequencer.sv
// Per-layer sequencer: walks the descriptor table and drives DMA load,
// PE clear, BSR scheduling and output drain for every layer.
module layer_sequencer
    import accel_ctrl_pkg::*;
#(
    parameter int unsigned M_W     = ACC_M_W,
    parameter int unsigned K_W     = ACC_K_W,
    parameter int unsigned ADDR_W  = ACC_ADDR_W,
    parameter int unsigned DESC_AW = 3,
    parameter int unsigned TMO_W   = 20
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start_i,
    input  logic               abort_i,
    input  logic [DESC_AW:0]   num_layers_i,
    output logic               busy_o,
    output logic               done_o,
    output logic               error_o,
    output logic [1:0]         err_code_o,
    output logic [DESC_AW-1:0] cur_layer_o,
    output logic [DESC_AW-1:0] desc_rd_addr_o,
    input  logic [M_W-1:0]     desc_mt_i,
    input  logic [K_W-1:0]     desc_kt_i,
    input  logic [ADDR_W-1:0]  desc_wgt_base_i,
    input  logic [ADDR_W-1:0]  desc_out_base_i,
    output logic               dma_start_o,
    output logic [ADDR_W-1:0]  dma_base_o,
    input  logic               dma_done_i,
    input  logic               dma_err_i,
    output logic               pe_clr_o,
    output logic               sched_start_o,
    output logic               sched_abort_o,
    output logic [M_W-1:0]     sched_mt_o,
    output logic [K_W-1:0]     sched_kt_o,
    input  logic               sched_done_i,
    output logic               drain_start_o,
    output logic [ADDR_W-1:0]  drain_base_o,
    input  logic               drain_done_i
);

    localparam logic [DESC_AW:0] LAYER_ONE = {{DESC_AW{1'b0}}, 1'b1};

    layer_state_e       state_q;
    layer_desc_t        desc_q;
    err_code_e          err_q;
    logic [DESC_AW:0]   count_q;
    logic [DESC_AW-1:0] cur_layer_q;
    logic [DESC_AW-1:0] addr_q;
    logic               busy_q;
    logic               done_q;
    logic               error_q;
    logic               abort_pend_q;
    logic               dma_start_q;
    logic               pe_clr_q;
    logic               sched_start_q;
    logic               sched_abort_q;
    logic               drain_start_q;

    logic [DESC_AW:0]   layer_nxt_d;
    logic               in_wait_d;
    logic               wd_clr_d;
    logic               wd_exp;
    logic               abort_hit_d;

    assign layer_nxt_d = {1'b0, cur_layer_q} + LAYER_ONE;
    assign abort_hit_d = abort_i || abort_pend_q;

    assign in_wait_d = (state_q == S_LOAD)
                    || (state_q == S_COMPUTE)
                    || (state_q == S_DRAIN);

    // COMPUTE hands over straight to DRAIN, so that edge re-arms too
    assign wd_clr_d = !in_wait_d
                   || ((state_q == S_COMPUTE) && sched_done_i);

    phase_watchdog #(
        .TMO_W     (TMO_W)
    ) u_wdog (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr_i     (wd_clr_d),
        .en_i      (in_wait_d),
        .expired_o (wd_exp)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            desc_q        <= '0;
            err_q         <= ERR_NONE;
            count_q       <= '0;
            cur_layer_q   <= '0;
            addr_q        <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            error_q       <= 1'b0;
            abort_pend_q  <= 1'b0;
            dma_start_q   <= 1'b0;
            pe_clr_q      <= 1'b0;
            sched_start_q <= 1'b0;
            sched_abort_q <= 1'b0;
            drain_start_q <= 1'b0;
        end else begin
            done_q        <= 1'b0;
            dma_start_q   <= 1'b0;
            pe_clr_q      <= 1'b0;
            sched_start_q <= 1'b0;
            sched_abort_q <= 1'b0;
            drain_start_q <= 1'b0;
            if (abort_hit_d && (state_q != S_IDLE)
                            && (state_q != S_ERR)) begin
                state_q      <= S_ERR;
                error_q      <= 1'b1;
                err_q        <= ERR_ABORT;
                abort_pend_q <= 1'b0;
            end else begin
                unique case (state_q)
                    S_IDLE: begin
                        if (start_i) begin
                            error_q <= 1'b0;
                            err_q   <= ERR_NONE;
                            if (num_layers_i == '0) begin
                                done_q <= 1'b1;
                            end else begin
                                count_q      <= num_layers_i;
                                cur_layer_q  <= '0;
                                addr_q       <= '0;
                                busy_q       <= 1'b1;
                                abort_pend_q <= abort_i;
                                state_q      <= S_DESC_ADDR;
                            end
                        end
                    end
                    S_DESC_ADDR: state_q <= S_DESC_CAP;
                    S_DESC_CAP: begin
                        desc_q.mt       <= ACC_M_W'(desc_mt_i);
                        desc_q.kt       <= ACC_K_W'(desc_kt_i);
                        desc_q.wgt_base <= ACC_ADDR_W'(desc_wgt_base_i);
                        desc_q.out_base <= ACC_ADDR_W'(desc_out_base_i);
                        if (desc_mt_i == '0) begin
                            state_q <= S_NEXT;
                        end else begin
                            state_q     <= S_LOAD;
                            dma_start_q <= 1'b1;
                        end
                    end
                    S_LOAD: begin
                        if (dma_err_i) begin
                            state_q <= S_ERR;
                            error_q <= 1'b1;
                            err_q   <= ERR_DMA;
                        end else if (dma_done_i) begin
                            state_q  <= S_CLEAR;
                            pe_clr_q <= 1'b1;
                        end else if (wd_exp) begin
                            state_q <= S_ERR;
                            error_q <= 1'b1;
                            err_q   <= ERR_TMO;
                        end
                    end
                    S_CLEAR: begin
                        state_q       <= S_COMPUTE;
                        sched_start_q <= 1'b1;
                    end
                    S_COMPUTE: begin
                        if (sched_done_i) begin
                            state_q       <= S_DRAIN;
                            drain_start_q <= 1'b1;
                        end else if (wd_exp) begin
                            state_q <= S_ERR;
                            error_q <= 1'b1;
                            err_q   <= ERR_TMO;
                        end
                    end
                    S_DRAIN: begin
                        if (drain_done_i) begin
                            state_q <= S_NEXT;
                        end else if (wd_exp) begin
                            state_q <= S_ERR;
                            error_q <= 1'b1;
                            err_q   <= ERR_TMO;
                        end
                    end
                    S_NEXT: begin
                        if (layer_nxt_d < count_q) begin
                            cur_layer_q <= layer_nxt_d[DESC_AW-1:0];
                            addr_q      <= layer_nxt_d[DESC_AW-1:0];
                            state_q     <= S_DESC_ADDR;
                        end else begin
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= S_IDLE;
                        end
                    end
                    S_ERR: begin
                        sched_abort_q <= 1'b1;
                        busy_q        <= 1'b0;
                        state_q       <= S_IDLE;
                    end
                    default: begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign busy_o         = busy_q;
    assign done_o         = done_q;
    assign error_o        = error_q;
    assign err_code_o     = err_q;
    assign cur_layer_o    = cur_layer_q;
    assign desc_rd_addr_o = addr_q;
    assign dma_start_o    = dma_start_q;
    assign dma_base_o     = ADDR_W'(desc_q.wgt_base);
    assign pe_clr_o       = pe_clr_q;
    assign sched_start_o  = sched_start_q;
    assign sched_abort_o  = sched_abort_q;
    assign sched_mt_o     = M_W'(desc_q.mt);
    assign sched_kt_o     = K_W'(desc_q.kt);
    assign drain_start_o  = drain_start_q;
    assign drain_base_o   = ADDR_W'(desc_q.out_base);

endmodule

// File: tb/tb_layer_sequencer.sv
// Directed bench for layer_sequencer with behavioural DMA, scheduler
// and drain responders; watchdog shortened to TMO_W=4.
module tb_layer_sequencer;

    localparam int M_W     = 10;
    localparam int K_W     = 12;
    localparam int ADDR_W  = 32;
    localparam int DESC_AW = 3;
    localparam int TMO_W   = 4;

    logic               clk = 1'b0;
    logic               rst_n = 1'b1;
    logic               start_i = 1'b0;
    logic               abort_i = 1'b0;
    logic [DESC_AW:0]   num_layers_i = '0;
    logic               busy_o, done_o, error_o;
    logic [1:0]         err_code_o;
    logic [DESC_AW-1:0] cur_layer_o, desc_rd_addr_o;
    logic [M_W-1:0]     desc_mt_i;
    logic [K_W-1:0]     desc_kt_i;
    logic [ADDR_W-1:0]  desc_wgt_base_i, desc_out_base_i;
    logic               dma_start_o, pe_clr_o;
    logic [ADDR_W-1:0]  dma_base_o, drain_base_o;
    logic               dma_done_i = 1'b0, dma_err_i = 1'b0;
    logic               sched_start_o, sched_abort_o;
    logic [M_W-1:0]     sched_mt_o;
    logic [K_W-1:0]     sched_kt_o;
    logic               sched_done_i = 1'b0;
    logic               drain_start_o;
    logic               drain_done_i = 1'b0;

    logic [M_W-1:0]    mt_tbl  [8];
    logic [K_W-1:0]    kt_tbl  [8];
    logic [ADDR_W-1:0] wgt_tbl [8];
    logic [ADDR_W-1:0] out_tbl [8];

    assign desc_mt_i       = mt_tbl[desc_rd_addr_o];
    assign desc_kt_i       = kt_tbl[desc_rd_addr_o];
    assign desc_wgt_base_i = wgt_tbl[desc_rd_addr_o];
    assign desc_out_base_i = out_tbl[desc_rd_addr_o];

    always #5 clk = ~clk;

    layer_sequencer #(
        .M_W     (M_W),
        .K_W     (K_W),
        .ADDR_W  (ADDR_W),
        .DESC_AW (DESC_AW),
        .TMO_W   (TMO_W)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .start_i         (start_i),
        .abort_i         (abort_i),
        .num_layers_i    (num_layers_i),
        .busy_o          (busy_o),
        .done_o          (done_o),
        .error_o         (error_o),
        .err_code_o      (err_code_o),
        .cur_layer_o     (cur_layer_o),
        .desc_rd_addr_o  (desc_rd_addr_o),
        .desc_mt_i       (desc_mt_i),
        .desc_kt_i       (desc_kt_i),
        .desc_wgt_base_i (desc_wgt_base_i),
        .desc_out_base_i (desc_out_base_i),
        .dma_start_o     (dma_start_o),
        .dma_base_o      (dma_base_o),
        .dma_done_i      (dma_done_i),
        .dma_err_i       (dma_err_i),
        .pe_clr_o        (pe_clr_o),
        .sched_start_o   (sched_start_o),
        .sched_abort_o   (sched_abort_o),
        .sched_mt_o      (sched_mt_o),
        .sched_kt_o      (sched_kt_o),
        .sched_done_i    (sched_done_i),
        .drain_start_o   (drain_start_o),
        .drain_base_o    (drain_base_o),
        .drain_done_i    (drain_done_i)
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    int cyc = 0;
    int n_dma, n_clr, n_sst, n_drn, n_abt, n_done;
    int c_dma_done, c_dma_err, c_clr, c_sst, c_drn_st, c_drn_done;
    int c_abt, c_done, c_err, c_bfall;
    logic err_prev = 1'b0, busy_prev = 1'b0;
    bit busy_seen;
    logic [M_W-1:0] mt_seq [$];
    int dma_lat = 5, sched_lat = 5, drain_lat = 5, err_layer = -1;
    int dma_cnt = 0, sched_cnt = 0, drain_cnt = 0;

    always @(negedge clk) begin
        cyc++;
        dma_done_i   = 1'b0;
        dma_err_i    = 1'b0;
        sched_done_i = 1'b0;
        drain_done_i = 1'b0;
        if (!rst_n) begin
            dma_cnt = 0; sched_cnt = 0; drain_cnt = 0;
        end
        if (dma_cnt > 0) begin
            dma_cnt--;
            if (dma_cnt == 0) begin
                if (int'(cur_layer_o) == err_layer) begin
                    dma_err_i = 1'b1; c_dma_err = cyc;
                end else begin
                    dma_done_i = 1'b1; c_dma_done = cyc;
                end
            end
        end
        if (sched_cnt > 0) begin
            sched_cnt--;
            if (sched_cnt == 0) sched_done_i = 1'b1;
        end
        if (drain_cnt > 0) begin
            drain_cnt--;
            if (drain_cnt == 0) begin
                drain_done_i = 1'b1; c_drn_done = cyc;
            end
        end
        if (dma_start_o) begin n_dma++; dma_cnt = dma_lat; end
        if (pe_clr_o) begin n_clr++; c_clr = cyc; end
        if (sched_start_o) begin
            n_sst++; c_sst = cyc;
            mt_seq.push_back(sched_mt_o);
            sched_cnt = sched_lat;
        end
        if (drain_start_o) begin
            n_drn++; c_drn_st = cyc; drain_cnt = drain_lat;
        end
        if (sched_abort_o) begin n_abt++; c_abt = cyc; end
        if (done_o) begin n_done++; c_done = cyc; end
        if (error_o && !err_prev) c_err = cyc;
        if (!busy_o && busy_prev) c_bfall = cyc;
        err_prev  = error_o;
        busy_prev = busy_o;
        if (busy_o) busy_seen = 1'b1;
    end

    task automatic clr_stats();
        n_dma = 0; n_clr = 0; n_sst = 0; n_drn = 0; n_abt = 0; n_done = 0;
        c_dma_done = -100; c_dma_err = -100; c_clr = -100; c_sst = -100;
        c_drn_st = -100; c_drn_done = -100; c_abt = -100; c_done = -100;
        c_err = -100; c_bfall = -100;
        busy_seen = 1'b0;
        mt_seq.delete();
    endtask

    task automatic load3(input int m0, input int m1, input int m2);
        mt_tbl[0] = M_W'(m0);
        mt_tbl[1] = M_W'(m1);
        mt_tbl[2] = M_W'(m2);
    endtask

    task automatic run(input int n);
        clr_stats();
        num_layers_i = DESC_AW'(n);
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int i = 0;
        while (busy_o && i < budget) begin
            @(negedge clk);
            i++;
        end
        check({tag, "_idle_tmo"}, 32'(i >= budget), 0);
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_sst(input int nth);
        int i = 0;
        int seen = 0;
        while (seen < nth && i < 300) begin
            @(negedge clk);
            i++;
            if (sched_start_o) seen++;
        end
        check("wait_sst_tmo", 32'(seen < nth), 0);
    endtask

    initial begin
        for (int i = 0; i < 8; i++) begin
            mt_tbl[i]  = M_W'(i + 1);
            kt_tbl[i]  = K_W'(3 * i + 5);
            wgt_tbl[i] = 32'h1000_0000 + 32'(i) * 32'h1000;
            out_tbl[i] = 32'h2000_0000 + 32'(i) * 32'h100;
        end
        clr_stats();
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", busy_o, 0);
        check("rst_done", done_o, 0);
        check("rst_error", error_o, 0);
        check("rst_code", err_code_o, 0);
        check("rst_dma_start", dma_start_o, 0);
        check("rst_sched_mt", sched_mt_o, 0);
        rst_n = 1'b1;
        @(negedge clk);

        load3(2, 4, 1);
        run(3);
        check("t3_busy_t1", busy_o, 1);
        check("t3_addr_t1", desc_rd_addr_o, 0);
        @(negedge clk);
        @(negedge clk);
        check("t3_dma_start_t3", dma_start_o, 1);
        check("t3_dma_base", dma_base_o, wgt_tbl[0]);
        wait_idle("t3", 300);
        check("t3_n_dma", n_dma, 3);
        check("t3_n_clr", n_clr, 3);
        check("t3_n_sst", n_sst, 3);
        check("t3_n_drn", n_drn, 3);
        check("t3_n_done", n_done, 1);
        check("t3_n_abt", n_abt, 0);
        check("t3_error", error_o, 0);
        check("t3_mt_len", mt_seq.size(), 3);
        if (mt_seq.size() == 3) begin
            check("t3_mt0", mt_seq[0], 2);
            check("t3_mt1", mt_seq[1], 4);
            check("t3_mt2", mt_seq[2], 1);
        end
        check("t3_clr_lat", c_clr - c_dma_done, 1);
        check("t3_sst_lat", c_sst - c_dma_done, 2);
        check("t3_done_lat", c_done - c_drn_done, 2);
        check("t3_drain_base", drain_base_o, out_tbl[2]);
        check("t3_sched_kt", sched_kt_o, kt_tbl[2]);
        check("t3_cur_layer", cur_layer_o, 2);

        run(0);
        check("z0_done", done_o, 1);
        check("z0_busy", busy_o, 0);
        @(negedge clk);
        check("z0_done_once", done_o, 0);
        @(negedge clk);
        check("z0_n_done", n_done, 1);
        check("z0_busy_seen", busy_seen, 0);

        load3(3, 0, 2);
        run(3);
        wait_idle("mt0", 300);
        check("mt0_n_dma", n_dma, 2);
        check("mt0_n_sst", n_sst, 2);
        if (mt_seq.size() == 2) check("mt0_mt1", mt_seq[1], 2);
        check("mt0_n_done", n_done, 1);
        check("mt0_cur_layer", cur_layer_o, 2);

        load3(2, 4, 1);
        err_layer = 1;
        run(3);
        wait_idle("dma", 300);
        err_layer = -1;
        check("dma_error", error_o, 1);
        check("dma_code", err_code_o, 1);
        check("dma_n_abt", n_abt, 1);
        check("dma_n_done", n_done, 0);
        check("dma_n_drn", n_drn, 1);
        check("dma_err_lat", c_err - c_dma_err, 1);
        check("dma_abt_lat", c_abt - c_dma_err, 2);
        check("dma_busy_lat", c_bfall - c_dma_err, 2);

        run(3);
        wait_sst(1);
        repeat (3) @(negedge clk);
        abort_i = 1'b1;
        @(negedge clk);
        abort_i = 1'b0;
        wait_idle("abt", 100);
        check("abt_error", error_o, 1);
        check("abt_code", err_code_o, 2);
        check("abt_n_abt", n_abt, 1);
        check("abt_n_done", n_done, 0);
        check("abt_n_drn", n_drn, 0);
        run(3);
        check("rerun_error_clr", error_o, 0);
        check("rerun_code_clr", err_code_o, 0);
        wait_idle("rerun", 300);
        check("rerun_n_done", n_done, 1);
        check("rerun_error", error_o, 0);

        clr_stats();
        num_layers_i = 4'd3;
        start_i = 1'b1;
        abort_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        abort_i = 1'b0;
        check("sa_busy", busy_o, 1);
        wait_idle("sa", 50);
        check("sa_code", err_code_o, 2);
        check("sa_n_dma", n_dma, 0);
        check("sa_n_done", n_done, 0);
        check("sa_n_abt", n_abt, 1);

        mt_tbl[0] = M_W'(1);
        drain_lat = 14;
        run(1);
        wait_idle("wd14", 200);
        check("wd14_error", error_o, 0);
        check("wd14_n_done", n_done, 1);
        drain_lat = 15;
        run(1);
        wait_idle("wd15", 200);
        check("wd15_code", err_code_o, 3);
        check("wd15_n_done", n_done, 0);
        check("wd15_lat", c_err - c_drn_st, 15);
        drain_lat = 0;
        run(1);
        wait_idle("wdno", 200);
        check("wdno_code", err_code_o, 3);
        check("wdno_n_abt", n_abt, 1);
        drain_lat = 5;
        repeat (20) @(negedge clk);

        load3(2, 4, 1);
        run(3);
        wait_sst(2);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mrst_busy", busy_o, 0);
        check("mrst_cur_layer", cur_layer_o, 0);
        check("mrst_sched_mt", sched_mt_o, 0);
        check("mrst_dma_base", dma_base_o, 0);
        check("mrst_drain_base", drain_base_o, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("mrst_idle_busy", busy_o, 0);
        run(1);
        wait_idle("mrst_run", 200);
        check("mrst_run_done", n_done, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
